pipe_adder: RTL

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 10 +
 rtl/adder_stage.sv | 58 +++++
 rtl/pipe_adder.sv | 58 +++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared stage record and stage-count derivation for pipe_adder
package pipe_adder_pkg;
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;
  function automatic int stages_of(input int width, input int chunk);
    return width / chunk;
  endfunction
endpackage

// File: rtl/adder_stage.sv
// adder_stage: one CHUNK-bit slice of the carry chain plus its pipeline register
module adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4,
  parameter int K = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stage_ctl_t       in_ctl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_s,
  input  logic             nxt_ready,
  output logic             advance,
  output stage_ctl_t       out_ctl,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_s
);
  stage_ctl_t ctl_q, ctl_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [CHUNK:0] part;
  always_comb begin
    part = {1'b0, in_a[K*CHUNK +: CHUNK]} + {1'b0, in_b[K*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, in_ctl.carry};
    advance = !ctl_q.valid || nxt_ready;
    ctl_d = ctl_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    if (advance) ctl_d.valid = in_ctl.valid;
    if (advance && in_ctl.valid) begin
      ctl_d.carry = part[CHUNK];
      a_d = in_a;
      b_d = in_b;
      s_d = in_s;
      s_d[K*CHUNK +: CHUNK] = part[CHUNK-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end
  assign out_ctl = ctl_q;
  assign out_a = a_q;
  assign out_b = b_q;
  assign out_s = s_q;
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: valid/ready pipelined adder, CHUNK bits of carry chain per stage.
// Define PIPE_ADDER_SUB_EN to add the sub port (a - b as a + ~b + 1).
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);
  localparam int STAGES = stages_of(WIDTH, CHUNK);
  stage_ctl_t ctl [STAGES+1];
  logic [WIDTH-1:0] av [STAGES+1];
  logic [WIDTH-1:0] bv [STAGES+1];
  logic [WIDTH-1:0] sv [STAGES+1];
  logic rdy [STAGES+1];
`ifdef PIPE_ADDER_SUB_EN
  // subtraction enters stage 0 as an inverted b with carry-in 1
  assign ctl[0] = '{valid: in_valid, carry: sub};
  assign bv[0] = sub ? ~b : b;
`else
  assign ctl[0] = '{valid: in_valid, carry: 1'b0};
  assign bv[0] = b;
`endif
  assign av[0] = a;
  assign sv[0] = '0;
  assign rdy[STAGES] = out_ready;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .K(k)) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .in_ctl(ctl[k]),
      .in_a(av[k]),
      .in_b(bv[k]),
      .in_s(sv[k]),
      .nxt_ready(rdy[k+1]),
      .advance(rdy[k]),
      .out_ctl(ctl[k+1]),
      .out_a(av[k+1]),
      .out_b(bv[k+1]),
      .out_s(sv[k+1])
    );
  end
  assign in_ready = rdy[0];
  assign out_valid = ctl[STAGES].valid;
  assign sum = {ctl[STAGES].carry, sv[STAGES]};
endmodule
